// File: rtl/thumb_fetch_queue.sv
// Thumb/Thumb-2 fetch queue: buffers fetched halfwords and presents whole 16/32-bit instructions.
// Latency: an instruction is presented the cycle after its last halfword is pushed.
// Backpressure: fetch stops when the queue is full; the head holds steady while inst_ready is low.
module thumb_fetch_queue #(
  parameter int             DEPTH    = 8,
  parameter int             AW       = 21,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_hw,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic          inst_is32,
  output logic [AW-1:0] inst_addr,
  output logic [31:0]   inst_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  logic [15:0]   q_mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr1;
  logic [CW-1:0] count;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] head_addr;
  logic [31:0]   icount;

  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          head_is32;
  logic          push;
  logic          pop;
  logic [1:0]    pop_n;

  // Second halfword of the head lives one slot later, wrapping naturally at DEPTH.
  assign rptr1     = rptr + PW'(1);
  assign h0        = q_mem[rptr];
  assign h1        = q_mem[rptr1];
  assign head_is32 = (h0[15:11] == 5'b11101) || (h0[15:11] == 5'b11110) ||
                     (h0[15:11] == 5'b11111);

  assign mem_req    = !rst && !flush && (count < FULL);
  assign mem_addr   = fetch_pc;
  assign inst_valid = !rst && !flush &&
                      (((count >= ONE) && !head_is32) || ((count >= TWO) && head_is32));
  assign inst       = head_is32 ? {h0, h1} : {h0, 16'h0000};
  assign inst_is32  = head_is32;
  assign inst_addr  = head_addr;
  assign inst_count = icount;

  assign push  = mem_req && mem_ack;
  assign pop   = inst_valid && inst_ready;
  assign pop_n = pop ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

  // Halfword storage; stale entries are never read because count gates the head.
  always_ff @(posedge clk) begin
    if (push) q_mem[wptr] <= mem_hw;
  end

  // Queue pointers, occupancy, fetch/consume addresses and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      fetch_pc  <= RESET_PC;
      head_addr <= RESET_PC;
      icount    <= '0;
    end else if (flush) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      fetch_pc  <= flush_pc;
      head_addr <= flush_pc;
    end else begin
      count <= count + CW'(push) - CW'(pop_n);
      if (push) begin
        wptr     <= wptr + PW'(1);
        fetch_pc <= fetch_pc + AW'(1);
      end
      if (pop) begin
        rptr      <= rptr + PW'(pop_n);
        head_addr <= head_addr + AW'(pop_n);
        icount    <= icount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_thumb_fetch_queue.sv
// Self-checking bench for thumb_fetch_queue: directed scenarios plus a randomized run against a queue model.
// Two instances: DEPTH=8 for most scenarios, DEPTH=4 for the wrap-spanning 32-bit case.
// Memory is an image indexed by low address bits, so every fetched halfword is known to the bench.
module tb_thumb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, flush, mem_ack, inst_ready;
  logic [20:0] flush_pc;

  logic        mem_req, inst_valid, inst_is32;
  logic [20:0] mem_addr, inst_addr;
  logic [15:0] mem_hw;
  logic [31:0] inst, inst_count;

  logic        mem_req4, inst_valid4, inst_is32_4;
  logic [20:0] mem_addr4, inst_addr4;
  logic [15:0] mem_hw4;
  logic [31:0] inst4, inst_count4;

  logic [15:0] memimg [1024];
  int total = 0;
  int bad   = 0;

  assign mem_hw  = memimg[mem_addr[9:0]];
  assign mem_hw4 = memimg[mem_addr4[9:0]];

  always #5 clk = ~clk;

  thumb_fetch_queue #(.DEPTH(8), .AW(21), .RESET_PC(21'd0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_hw(mem_hw),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_is32(inst_is32), .inst_addr(inst_addr), .inst_count(inst_count)
  );

  thumb_fetch_queue #(.DEPTH(4), .AW(21), .RESET_PC(21'd0)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req4), .mem_addr(mem_addr4), .mem_ack(mem_ack), .mem_hw(mem_hw4),
    .inst_valid(inst_valid4), .inst_ready(inst_ready), .inst(inst4),
    .inst_is32(inst_is32_4), .inst_addr(inst_addr4), .inst_count(inst_count4)
  );

  function automatic bit m_is32(input logic [15:0] h);
    return h[15:11] inside {5'b11101, 5'b11110, 5'b11111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 1024; i++) memimg[i] = {3'b001, 13'($urandom)};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; mem_ack = 1'b1; inst_ready = 1'b1; flush_pc = '0;
    fill16();
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%0h exp=0", inst_valid); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL post_reset_mem_req got=%0h exp=1", mem_req); end
    total++; if (mem_addr !== 21'd0) begin bad++; $display("FAIL post_reset_mem_addr got=%0h exp=0", mem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL post_reset_inst_valid got=%0h exp=0", inst_valid); end
    total++; if (inst_count !== 32'd0) begin bad++; $display("FAIL post_reset_inst_count got=%0h exp=0", inst_count); end
    total++; if (mem_addr4 !== 21'd0) begin bad++; $display("FAIL post_reset_mem_addr4 got=%0h exp=0", mem_addr4); end
  endtask

  task automatic test_stream16();
    logic [31:0] exp [3];
    int n;
    exp[0] = 32'h2001_0000; exp[1] = 32'h2102_0000; exp[2] = 32'hBF08_0000;
    fill16();
    memimg[0] = 16'h2001; memimg[1] = 16'h2102; memimg[2] = 16'hBF08;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      #1;
      if (inst_valid) begin
        total++; if (inst !== exp[n]) begin bad++; $display("FAIL s16_inst%0d got=%h exp=%h", n, inst, exp[n]); end
        total++; if (inst_addr !== 21'(n)) begin bad++; $display("FAIL s16_addr%0d got=%h exp=%h", n, inst_addr, n); end
        total++; if (inst_is32 !== 1'b0) begin bad++; $display("FAIL s16_is32_%0d got=%0h exp=0", n, inst_is32); end
        n++;
      end
      if (n < 3) tick();
    end
    total++; if (n != 3) begin bad++; $display("FAIL s16_timeout got=%0d exp=3", n); end
    tick();
    inst_ready = 1'b0;
    #1;
    total++; if (inst_count !== 32'd3) begin bad++; $display("FAIL s16_count got=%0d exp=3", inst_count); end
  endtask

  task automatic test_thumb32();
    bit seen;
    fill16();
    memimg[0] = 16'hF000; memimg[1] = 16'hF800;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (inst_valid) begin
        seen = 1'b1;
        total++; if (inst !== 32'hF000_F800) begin bad++; $display("FAIL t32_inst got=%h exp=f000f800", inst); end
        total++; if (inst_is32 !== 1'b1) begin bad++; $display("FAIL t32_is32 got=%0h exp=1", inst_is32); end
        total++; if (inst_addr !== 21'd0) begin bad++; $display("FAIL t32_addr got=%h exp=0", inst_addr); end
      end
      tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL t32_timeout got=0 exp=1"); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (inst_valid) begin
        seen = 1'b1;
        total++; if (inst_addr !== 21'd2) begin bad++; $display("FAIL t32_next_addr got=%h exp=2", inst_addr); end
      end
      else tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL t32_next_timeout got=0 exp=1"); end
  endtask

  task automatic test_full();
    int e;
    fill16();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    repeat (8) tick();
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_mem_req got=%0h exp=0", mem_req); end
    total++; if (mem_addr !== 21'd8) begin bad++; $display("FAIL full_mem_addr got=%h exp=8", mem_addr); end
    total++; if (inst_valid !== 1'b1 || inst_addr !== 21'd0) begin bad++; $display("FAIL full_head got=%0h/%h exp=1/0", inst_valid, inst_addr); end
    inst_ready = 1'b1;
    e = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      total++;
      if (inst_valid !== 1'b1 || inst_addr !== 21'(e) || inst !== {memimg[e], 16'h0000}) begin
        bad++; $display("FAIL full_seq%0d got=%0h/%h/%h exp=1/%h/%h", c, inst_valid, inst_addr, inst, e, {memimg[e], 16'h0000});
      end
      e++;
    end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL full_steady_mem_req got=%0h exp=1", mem_req); end
    inst_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit seen;
    fill16();
    memimg[3] = 16'hF123; memimg[4] = 16'hF8AB;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    repeat (4) tick();
    #1;
    total++; if (mem_req4 !== 1'b0) begin bad++; $display("FAIL wrap_full got=%0h exp=0", mem_req4); end
    inst_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      #1;
      if (inst_valid4 && inst_addr4 == 21'd3) begin
        seen = 1'b1;
        total++; if (inst4 !== 32'hF123_F8AB) begin bad++; $display("FAIL wrap_inst got=%h exp=f123f8ab", inst4); end
        total++; if (inst_is32_4 !== 1'b1) begin bad++; $display("FAIL wrap_is32 got=%0h exp=1", inst_is32_4); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL wrap_timeout got=0 exp=1"); end
    inst_ready = 1'b0;
  endtask

  task automatic test_flush();
    fill16();
    memimg[10'h100] = 16'h2155;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (4) tick();
    flush = 1'b1; flush_pc = 21'h100;
    #1;
    total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL flush_gate got=%0h/%0h exp=0/0", mem_req, inst_valid); end
    tick();
    flush = 1'b0;
    #1;
    total++; if (mem_addr !== 21'h100) begin bad++; $display("FAIL flush_mem_addr got=%h exp=100", mem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0h exp=0", inst_valid); end
    total++; if (inst_count !== 32'd1) begin bad++; $display("FAIL flush_count got=%0d exp=1", inst_count); end
    tick();
    #1;
    total++; if (inst_valid !== 1'b1 || inst_addr !== 21'h100) begin bad++; $display("FAIL flush_first got=%0h/%h exp=1/100", inst_valid, inst_addr); end
    total++; if (inst !== 32'h2155_0000) begin bad++; $display("FAIL flush_inst got=%h exp=21550000", inst); end
  endtask

  task automatic test_reset_mid();
    fill16();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    repeat (3) tick();
    inst_ready = 1'b1;
    tick();
    mem_ack = 1'b0; rst = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rmid_during got=%0h/%0h exp=0/0", mem_req, inst_valid); end
    tick();
    #1;
    total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rmid_during2 got=%0h/%0h exp=0/0", mem_req, inst_valid); end
    rst = 1'b0;
    #1;
    total++; if (mem_addr !== 21'd0) begin bad++; $display("FAIL rmid_mem_addr got=%h exp=0", mem_addr); end
    total++; if (inst_count !== 32'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", inst_count); end
    total++; if (inst_valid !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL rmid_after got=%0h/%0h exp=0/1", inst_valid, mem_req); end
    inst_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [20:0] fpc, ia;
    logic [31:0] ic, exp_inst;
    bit m_req, m_h32, m_valid;
    for (int i = 0; i < 1024; i++) begin
      memimg[i] = 16'($urandom);
      if ($urandom_range(0, 2) == 0) memimg[i][15:11] = 5'(29 + $urandom_range(0, 2));
    end
    do_reset();
    fpc = '0; ia = '0; ic = '0;
    for (int c = 0; c < 3000; c++) begin
      mem_ack    = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 63) == 0);
      flush_pc   = 21'($urandom);
      #1;
      m_req   = !flush && (q.size() < 8);
      m_h32   = (q.size() > 0) && m_is32(q[0]);
      m_valid = !flush && (((q.size() >= 1) && !m_h32) || ((q.size() >= 2) && m_h32));
      total++; if (mem_req !== m_req) begin bad++; $display("FAIL rnd_mem_req c=%0d got=%0h exp=%0h", c, mem_req, m_req); end
      if (m_req) begin
        total++; if (mem_addr !== fpc) begin bad++; $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, mem_addr, fpc); end
      end
      total++; if (inst_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%0h exp=%0h", c, inst_valid, m_valid); end
      if (m_valid) begin
        exp_inst = m_h32 ? {q[0], q[1]} : {q[0], 16'h0000};
        total++;
        if (inst !== exp_inst || inst_is32 !== m_h32 || inst_addr !== ia || inst_count !== ic) begin
          bad++; $display("FAIL rnd_head c=%0d got=%h/%0h/%h/%0d exp=%h/%0h/%h/%0d", c, inst, inst_is32, inst_addr, inst_count, exp_inst, m_h32, ia, ic);
        end
      end
      if (flush) begin
        q.delete();
        fpc = flush_pc;
        ia  = flush_pc;
      end else begin
        if (m_valid && inst_ready) begin
          void'(q.pop_front());
          if (m_h32) void'(q.pop_front());
          ia = ia + (m_h32 ? 21'd2 : 21'd1);
          ic = ic + 32'd1;
        end
        if (m_req && mem_ack) begin
          q.push_back(memimg[fpc[9:0]]);
          fpc = fpc + 21'd1;
        end
      end
      tick();
    end
    flush = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = '0; mem_ack = 1'b0; inst_ready = 1'b0;
    test_reset();
    test_stream16();
    test_thumb32();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
